// File: rtl/dist_topk_select.sv
// dist_topk_select
//   K-nearest-neighbour selection stage. Takes one (distance, index) pair
//   per handshake and keeps the K smallest distances in ascending order.
//   Each accepted pair needs two cycles: one to capture it, one to insert it.
//   Once the pair flagged LAST has been inserted, the list is frozen and
//   OUT_Done stays high until CLR or RST.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   RST        asynchronous active-high reset
//   CLR        synchronous clear; beats IN_Valid in every state
//   IN_Valid   IN_Dist / IN_Idx / IN_Last are valid
//   IN_Ready   a pair can be accepted this cycle
//   IN_Dist    unsigned distance
//   IN_Idx     index of the vector that produced IN_Dist
//   IN_Last    final pair of the query
//   OUT_Dists  sorted distances, slot 0 (smallest) in the LSBs
//   OUT_Idxs   indices matching OUT_Dists, same packing
//   OUT_Count  number of occupied slots, 0..K
//   OUT_Done   high once the LAST pair has been inserted
module dist_topk_select #(
    parameter int VARWIDTH = 32,
    parameter int IDXWIDTH = 8,
    parameter int K        = 4,
    localparam int CW      = $clog2(K + 1)
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     CLR,
    input  logic                     IN_Valid,
    output logic                     IN_Ready,
    input  logic [VARWIDTH-1:0]      IN_Dist,
    input  logic [IDXWIDTH-1:0]      IN_Idx,
    input  logic                     IN_Last,
    output logic [VARWIDTH*K-1:0]    OUT_Dists,
    output logic [IDXWIDTH*K-1:0]    OUT_Idxs,
    output logic [CW-1:0]            OUT_Count,
    output logic                     OUT_Done
);

    typedef enum logic [1:0] {S_ACCEPT, S_INSERT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [VARWIDTH-1:0]   r_dist [K];
    logic [IDXWIDTH-1:0]   r_idx  [K];
    logic [CW-1:0]         r_count;

    logic [VARWIDTH-1:0]   r_hold_dist;
    logic [IDXWIDTH-1:0]   r_hold_idx;
    logic                  r_hold_last;

    logic [K-1:0]          w_keep;
    logic [VARWIDTH-1:0]   w_dist_next [K];
    logic [IDXWIDTH-1:0]   w_idx_next  [K];

    // Slot i keeps its entry when it is occupied and not larger than the held
    // distance. Because the occupied slots are sorted, the kept slots form a
    // prefix whose length is the insert position p. The first non-kept slot
    // takes the held pair and every slot after it takes its lower neighbour,
    // dropping slot K-1. When all K slots are kept (p == K) nothing changes.
    for (genvar gi = 0; gi < K; gi++) begin : g_slot
        assign w_keep[gi] = (CW'(gi) < r_count) && (r_dist[gi] <= r_hold_dist);

        if (gi == 0) begin : g_first
            assign w_dist_next[gi] = w_keep[gi] ? r_dist[gi] : r_hold_dist;
            assign w_idx_next[gi]  = w_keep[gi] ? r_idx[gi]  : r_hold_idx;
        end else begin : g_rest
            assign w_dist_next[gi] = w_keep[gi]     ? r_dist[gi]  :
                                     w_keep[gi - 1] ? r_hold_dist : r_dist[gi - 1];
            assign w_idx_next[gi]  = w_keep[gi]     ? r_idx[gi]   :
                                     w_keep[gi - 1] ? r_hold_idx  : r_idx[gi - 1];
        end

        assign OUT_Dists[gi*VARWIDTH +: VARWIDTH] = r_dist[gi];
        assign OUT_Idxs[gi*IDXWIDTH +: IDXWIDTH]  = r_idx[gi];
    end

    assign OUT_Count = r_count;

    // State register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= S_ACCEPT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and status outputs
    always_comb begin
        w_state_next = r_state;
        IN_Ready     = 1'b0;
        OUT_Done     = 1'b0;
        case (r_state)
            S_ACCEPT: begin
                IN_Ready = 1'b1;
                if (IN_Valid) begin
                    w_state_next = S_INSERT;
                end
            end
            S_INSERT: begin
                w_state_next = r_hold_last ? S_DONE : S_ACCEPT;
            end
            S_DONE: begin
                OUT_Done = 1'b1;
            end
            default: begin
                w_state_next = S_ACCEPT;
            end
        endcase
        if (CLR) begin
            w_state_next = S_ACCEPT;
        end
    end

    // Hold register for the accepted pair
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_hold_dist <= '0;
            r_hold_idx  <= '0;
            r_hold_last <= 1'b0;
        end else if (!CLR && r_state == S_ACCEPT && IN_Valid) begin
            r_hold_dist <= IN_Dist;
            r_hold_idx  <= IN_Idx;
            r_hold_last <= IN_Last;
        end
    end

    // Sorted list and occupancy. Occupancy is tracked by the counter rather
    // than by slot value, so a real all-ones distance is still inserted.
    // Whenever the count is below K, slot K-1 is empty and p < K, so the
    // count increments on every insert that finds room.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < K; i++) begin
                r_dist[i] <= '1;
                r_idx[i]  <= '1;
            end
            r_count <= '0;
        end else if (CLR) begin
            for (int i = 0; i < K; i++) begin
                r_dist[i] <= '1;
                r_idx[i]  <= '1;
            end
            r_count <= '0;
        end else if (r_state == S_INSERT) begin
            for (int i = 0; i < K; i++) begin
                r_dist[i] <= w_dist_next[i];
                r_idx[i]  <= w_idx_next[i];
            end
            if (r_count < CW'(K)) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

endmodule
